// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I main controller.
package ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        LOAD   = 3'd0,
        STORE  = 3'd1,
        RTYPE  = 3'd2,
        ITYPE  = 3'd3,
        BRANCH = 3'd4
    } iclass_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam int         ALU_CTRL_W = 4;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational funct decode: instruction class + funct fields -> ALU control
// code, flagging encodings the controller does not support.
module alu_ctrl_decode
    import ctrl_pkg::*;
(
    input  iclass_e               cls_i,
    input  logic [2:0]            funct3_i,
    input  logic [6:0]            funct7_i,
    output logic [ALU_CTRL_W-1:0] alu_ctrl_o,
    output logic                  illegal_op_o
);

    // Per-class funct3/funct7 legality and ALU operation select.
    always_comb begin
        alu_ctrl_o   = ALU_ADD;
        illegal_op_o = 1'b0;
        case (cls_i)
            LOAD, STORE: illegal_op_o = (funct3_i != 3'b010);
            BRANCH: begin
                alu_ctrl_o   = ALU_SUB;
                illegal_op_o = (funct3_i != 3'b000);
            end
            RTYPE, ITYPE: begin
                case (funct3_i)
                    3'b000:  alu_ctrl_o = (cls_i == RTYPE && funct7_i == F7_ALT) ? ALU_SUB : ALU_ADD;
                    3'b111:  alu_ctrl_o = ALU_AND;
                    3'b110:  alu_ctrl_o = ALU_OR;
                    3'b010:  alu_ctrl_o = ALU_SLT;
                    default: illegal_op_o = 1'b1;
                endcase
                // R-type only tolerates the base funct7, plus the alternate one for SUB.
                if (cls_i == RTYPE && funct7_i != F7_BASE &&
                    !(funct3_i == 3'b000 && funct7_i == F7_ALT))
                    illegal_op_o = 1'b1;
            end
            default: illegal_op_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I main controller: FETCH/DECODE/EXEC/MEM/WB sequencing with
// a memory ready handshake, per-access timeout and sticky trap flags.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int ALUCTRL_W   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic                 mem_ready,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 RegWrite,
    output logic                 MemtoReg,
    output logic [1:0]           ALUOp,
    output logic                 ALUSrc,
    output logic                 Branch,
    output logic [ALUCTRL_W-1:0] ALUCtrl,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic                 instr_done,
    output logic                 illegal,
    output logic                 timeout,
    output logic [2:0]           state
);

    // A zero timeout disables the counter; keep it at least one bit wide.
    localparam int            CW       = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam bit            TO_EN    = (MEM_TIMEOUT > 0);
    localparam logic [CW-1:0] CNT_LAST = TO_EN ? CW'(MEM_TIMEOUT - 1) : '0;

    state_e                  state_q, state_d;
    iclass_e                 cls_q, cls_d, cls_dec;
    logic [ALU_CTRL_W-1:0]   alu_q, alu_d, alu_dec;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    illegal_q, illegal_d, timeout_q, timeout_d;
    logic                    op_ok, dec_illegal, wait_req;

    // Opcode -> instruction class; unknown opcodes are flagged here.
    always_comb begin
        op_ok   = 1'b1;
        cls_dec = LOAD;
        case (opcode)
            OP_LOAD:   cls_dec = LOAD;
            OP_STORE:  cls_dec = STORE;
            OP_RTYPE:  cls_dec = RTYPE;
            OP_ITYPE:  cls_dec = ITYPE;
            OP_BRANCH: cls_dec = BRANCH;
            default:   op_ok   = 1'b0;
        endcase
    end

    alu_ctrl_decode u_dec (
        .cls_i        (cls_dec),
        .funct3_i     (funct3),
        .funct7_i     (funct7),
        .alu_ctrl_o   (alu_dec),
        .illegal_op_o (dec_illegal)
    );

    // Next-state, DECODE latching and memory wait timeout.
    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        alu_d     = alu_q;
        cnt_d     = '0;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        wait_req  = 1'b0;
        case (state_q)
            FETCH: if (mem_ready) state_d = DECODE; else wait_req = 1'b1;
            DECODE: begin
                if (!op_ok || dec_illegal) begin
                    state_d   = TRAP;
                    illegal_d = 1'b1;
                end else begin
                    cls_d   = cls_dec;
                    alu_d   = alu_dec;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cls_q == LOAD || cls_q == STORE) state_d = MEM;
                else if (cls_q == BRANCH)            state_d = FETCH;
                else                                 state_d = WB;
            end
            MEM:     if (mem_ready) state_d = (cls_q == LOAD) ? WB : FETCH; else wait_req = 1'b1;
            WB:      state_d = FETCH;
            TRAP:    state_d = TRAP;
            default: state_d = FETCH;
        endcase
        // Ready in the limit cycle never reaches here, so ready wins the tie.
        if (wait_req && TO_EN) begin
            if (cnt_q == CNT_LAST) begin
                state_d   = TRAP;
                timeout_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // State, latched decode and sticky flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= FETCH;
            cls_q     <= LOAD;
            alu_q     <= ALU_ADD;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            alu_q     <= alu_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // Strobes from state and latched class; forced low while reset is held.
    always_comb begin
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        MemtoReg   = 1'b0;
        ALUOp      = ALUOP_ADD;
        ALUSrc     = 1'b0;
        Branch     = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        instr_done = 1'b0;
        if (reset) begin
            case (state_q)
                FETCH: begin
                    MemRead = 1'b1;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                EXEC: begin
                    case (cls_q)
                        LOAD, STORE: begin ALUOp = ALUOP_ADD; ALUSrc = 1'b1; end
                        RTYPE:       ALUOp = ALUOP_FUNCT;
                        ITYPE:       begin ALUOp = ALUOP_FUNCT; ALUSrc = 1'b1; end
                        BRANCH: begin
                            ALUOp      = ALUOP_BR;
                            Branch     = 1'b1;
                            instr_done = 1'b1;
                        end
                        default: ;
                    endcase
                end
                MEM: begin
                    if (cls_q == LOAD) begin
                        MemRead = 1'b1;
                    end else begin
                        MemWrite   = 1'b1;
                        instr_done = mem_ready;
                    end
                end
                WB: begin
                    RegWrite   = 1'b1;
                    MemtoReg   = (cls_q == LOAD);
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ALUCtrl = ALUCTRL_W'(alu_q);
    assign illegal = illegal_q;
    assign timeout = timeout_q;
    assign state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed instructions, expected retire records
// queued at issue and compared by a monitor on each instr_done pulse.
module tb_multicycle_ctrl;

    localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_T = 3'd5;

    logic       clk, reset, mem_ready;
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic       MemRead, MemWrite, RegWrite, MemtoReg, ALUSrc, Branch;
    logic       IRWrite, PCWrite, instr_done, illegal, timeout;
    logic [1:0] ALUOp;
    logic [3:0] ALUCtrl;
    logic [2:0] state;

    multicycle_ctrl #(.MEM_TIMEOUT(4), .ALUCTRL_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .mem_ready(mem_ready), .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .MemtoReg(MemtoReg), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .Branch(Branch),
        .ALUCtrl(ALUCtrl), .IRWrite(IRWrite), .PCWrite(PCWrite), .instr_done(instr_done),
        .illegal(illegal), .timeout(timeout), .state(state)
    );

    wire [10:0] strobes = {MemRead, MemWrite, RegWrite, MemtoReg, ALUSrc, Branch,
                           IRWrite, PCWrite, instr_done, ALUOp};

    typedef struct {
        string       name;
        int          lat;
        logic [23:0] trace;
        logic [3:0]  alu;
        logic [1:0]  aluop;
        logic        src, br, regw, m2r;
        int          mwc, mrc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, errors = 0;
    int   fetch_wait = 0, mem_wait = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Memory model: ready after a programmed number of wait cycles per access;
    // held high outside memory states, where the controller must ignore it.
    int         wcnt = 0;
    logic [2:0] prev_st = S_F;
    always begin
        @(posedge clk);
        #2;
        if (!reset) begin
            wcnt = 0; prev_st = S_F; mem_ready = 1'b0;
        end else begin
            if (state != prev_st) wcnt = 0;
            prev_st = state;
            if (state == S_F)      mem_ready = (wcnt >= fetch_wait);
            else if (state == S_M) mem_ready = (wcnt >= mem_wait);
            else                   mem_ready = 1'b1;
            wcnt++;
        end
    end

    // Monitor: accumulate per-instruction observations, compare at retirement.
    int          m_cyc = 0, m_mr = 0, m_mw = 0;
    logic [23:0] m_tr = '0;
    logic [3:0]  m_alu = '0;
    logic [1:0]  m_op = '0;
    logic        m_src = 0, m_br = 0, m_rw = 0, m_m2r = 0;
    always @(negedge clk) begin
        if (!reset) begin
            m_cyc = 0; m_mr = 0; m_mw = 0; m_tr = '0; m_rw = 0; m_m2r = 0;
        end else begin
            m_cyc++;
            m_tr = {m_tr[20:0], state};
            if (MemRead)  m_mr++;
            if (MemWrite) m_mw++;
            if (RegWrite) begin m_rw = 1'b1; m_m2r = MemtoReg; end
            if (state == S_E) begin m_alu = ALUCtrl; m_op = ALUOp; m_src = ALUSrc; m_br = Branch; end
            if (instr_done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk({e.name, "_latency"}, m_cyc, e.lat);
                    chk({e.name, "_states"}, m_tr, e.trace);
                    chk({e.name, "_aluctrl"}, m_alu, e.alu);
                    chk({e.name, "_aluop"}, m_op, e.aluop);
                    chk({e.name, "_alusrc"}, m_src, e.src);
                    chk({e.name, "_branch"}, m_br, e.br);
                    chk({e.name, "_regwrite"}, m_rw, e.regw);
                    chk({e.name, "_memtoreg"}, m_m2r, e.m2r);
                    chk({e.name, "_memwrite_cyc"}, m_mw, e.mwc);
                    chk({e.name, "_memread_cyc"}, m_mr, e.mrc);
                end
                m_cyc = 0; m_mr = 0; m_mw = 0; m_tr = '0; m_rw = 0; m_m2r = 0;
            end
        end
    end

    // Issue one instruction, queue its expected retirement, scramble the
    // instruction fields once EXEC is reached, then wait for retirement.
    task automatic issue(input string nm, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input int fw, input int mw, input int lat,
                         input logic [23:0] tr, input logic [3:0] alu, input logic [1:0] aop,
                         input logic src, input logic br, input logic regw, input logic m2r,
                         input int mwc, input int mrc);
        exp_t e;
        bit   seen;
        e.name = nm; e.lat = lat; e.trace = tr; e.alu = alu; e.aluop = aop;
        e.src = src; e.br = br; e.regw = regw; e.m2r = m2r; e.mwc = mwc; e.mrc = mrc;
        sb.push_back(e);
        opcode = op; funct3 = f3; funct7 = f7; fetch_wait = fw; mem_wait = mw;
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(posedge clk); #1;
            if (state == S_E) seen = 1;
        end
        if (!seen) chk({nm, "_reach_exec"}, 0, 1);
        opcode = 7'h7F; funct3 = 3'b101; funct7 = 7'h7F;
        seen = (instr_done === 1'b1);
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (instr_done) seen = 1;
        end
        if (!seen) chk({nm, "_retire"}, 0, 1);
    endtask

    task automatic run_trap(input string nm, input logic [6:0] op, input logic [2:0] f3,
                            input logic [6:0] f7, input bit hold);
        int bad;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        opcode = op; funct3 = f3; funct7 = f7; fetch_wait = 0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk({nm, "_state"}, state, S_T);
        chk({nm, "_illegal"}, illegal, 1);
        chk({nm, "_timeout"}, timeout, 0);
        if (hold) begin
            bad = 0;
            repeat (20) begin
                @(negedge clk);
                if (strobes != 0 || state != S_T || illegal != 1'b1) bad++;
            end
            chk({nm, "_hold_bad_cycles"}, bad, 0);
        end
    endtask

    initial begin
        reset = 1'b0; opcode = '0; funct3 = '0; funct7 = '0; mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", state, S_F);
        chk("rst_strobes", strobes, 0);
        chk("rst_aluctrl", ALUCtrl, 4'b0010);
        chk("rst_flags", {illegal, timeout}, 0);

        @(posedge clk); #1;
        reset = 1'b1;
        //    name    opcode      f3      f7          fw mw lat trace                                  alu      aop    src br rw m2r mw mr
        issue("lw",   7'b0000011, 3'b010, 7'b0000000, 0, 0, 5, 24'({S_F,S_D,S_E,S_M,S_W}),         4'b0010, 2'b00, 1, 0, 1, 1, 0, 2);
        issue("sub",  7'b0110011, 3'b000, 7'b0100000, 0, 0, 4, 24'({S_F,S_D,S_E,S_W}),             4'b0110, 2'b10, 0, 0, 1, 0, 0, 1);
        issue("and",  7'b0110011, 3'b111, 7'b0000000, 0, 0, 4, 24'({S_F,S_D,S_E,S_W}),             4'b0000, 2'b10, 0, 0, 1, 0, 0, 1);
        issue("addi", 7'b0010011, 3'b000, 7'b0100000, 0, 0, 4, 24'({S_F,S_D,S_E,S_W}),             4'b0010, 2'b10, 1, 0, 1, 0, 0, 1);
        issue("ori",  7'b0010011, 3'b110, 7'b0000000, 0, 0, 4, 24'({S_F,S_D,S_E,S_W}),             4'b0001, 2'b10, 1, 0, 1, 0, 0, 1);
        issue("slt",  7'b0110011, 3'b010, 7'b0000000, 0, 0, 4, 24'({S_F,S_D,S_E,S_W}),             4'b0111, 2'b10, 0, 0, 1, 0, 0, 1);
        issue("sw",   7'b0100011, 3'b010, 7'b0000000, 0, 3, 7, 24'({S_F,S_D,S_E,S_M,S_M,S_M,S_M}), 4'b0010, 2'b00, 1, 0, 0, 0, 4, 1);
        issue("beq",  7'b1100011, 3'b000, 7'b0000000, 3, 0, 6, 24'({S_F,S_F,S_F,S_F,S_D,S_E}),     4'b0110, 2'b01, 0, 1, 0, 0, 0, 4);
        chk("run_flags", {illegal, timeout}, 0);

        // Reset in the middle of a store with MemWrite asserted.
        opcode = 7'b0100011; funct3 = 3'b010; funct7 = '0; fetch_wait = 0; mem_wait = 1000;
        for (int i = 0; i < 20 && state != S_M; i++) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("midrst_pre_memwrite", MemWrite, 1);
        #1 reset = 1'b0;
        #1;
        chk("midrst_state", state, S_F);
        chk("midrst_strobes", strobes, 0);
        chk("midrst_flags", {illegal, timeout}, 0);

        // Release with memory never ready: four wait cycles, then timeout trap.
        fetch_wait = 1000;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rel_memread", MemRead, 1);
        repeat (3) @(negedge clk);
        chk("to_state_4th_wait", state, S_F);
        @(negedge clk);
        chk("to_state", state, S_T);
        chk("to_timeout", timeout, 1);
        chk("to_illegal", illegal, 0);
        chk("to_strobes", strobes, 0);

        run_trap("bad_opcode", 7'b1111111, 3'b000, 7'b0000000, 1);
        run_trap("bad_rtype_f7", 7'b0110011, 3'b000, 7'b0000001, 0);
        run_trap("bad_sw_f3", 7'b0100011, 3'b000, 7'b0000000, 0);

        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle successor to the single-cycle RV32I main controller.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB using a memory ready handshake with a parametrised timeout.
- Decodes a wider instruction subset (LW, SW, R-type, I-type ALU, BEQ) and produces a 4-bit ALU control code.
- Sits between the instruction register/decoder and the datapath muxes, register file, PC and memory port.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles to wait for mem_ready per access. 0 disables the timeout.
- ALUCTRL_W, 4: width of ALUCtrl.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- opcode  in  7  instruction opcode from IR, stable after IRWrite.
- funct3  in  3  instruction funct3.
- funct7  in  7  instruction funct7.
- mem_ready  in  1  memory has completed the current read/write.
- MemRead  out  1  memory read request (fetch or load).
- MemWrite  out  1  memory write request (store).
- RegWrite  out  1  register file write enable.
- MemtoReg  out  1  writeback mux: 1 = memory data, 0 = ALU result.
- ALUOp  out  2  00 add (address), 01 branch compare, 10 funct-decoded.
- ALUSrc  out  1  ALU B operand: 1 = immediate, 0 = rs2.
- Branch  out  1  branch-compare cycle; datapath gates the PC load with zero.
- ALUCtrl  out  ALUCTRL_W  AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111.
- IRWrite  out  1  load IR from fetched word.
- PCWrite  out  1  PC <= PC+4.
- instr_done  out  1  one-cycle pulse on instruction retirement.
- illegal  out  1  sticky: unsupported encoding trapped.
- timeout  out  1  sticky: memory did not respond within MEM_TIMEOUT.
- state  out  3  current state, for debug.

Behaviour:
- Reset (async assert, sync release):
  - state = FETCH; every output 0 except ALUCtrl = 0010.
  - Class/ALUCtrl registers and timeout counter cleared; illegal and timeout cleared.
- Outputs are Moore: a function of state plus the class and ALUCtrl registers latched in DECODE. Changes on opcode/funct inputs after DECODE have no effect.
- FETCH: MemRead = 1 until mem_ready. In the mem_ready cycle, IRWrite = 1 and PCWrite = 1 for that single cycle; next state is DECODE.
- DECODE (1 cycle): latch class and ALUCtrl.
  - Legal encodings:
    - LW: opcode 0000011, funct3 010.
    - SW: opcode 0100011, funct3 010.
    - R-type: opcode 0110011; funct3 000 gives ADD, or SUB when funct7 = 0100000. funct3 111/110/010 give AND/OR/SLT. R-type requires funct7 of 0000000, except 0100000 for SUB.
    - I-type ALU: opcode 0010011; funct3 000/111/110/010, funct7 ignored.
    - BEQ: opcode 1100011, funct3 000.
  - Anything else: next state TRAP, illegal = 1.
- EXEC (1 cycle):
  - LW/SW: ALUOp 00, ALUSrc 1, next state MEM.
  - R-type: ALUOp 10, ALUSrc 0, next state WB.
  - I-type: ALUOp 10, ALUSrc 1, next state WB.
  - BEQ: ALUOp 01, ALUSrc 0, Branch 1, ALUCtrl SUB, instr_done 1, next state FETCH.
- MEM:
  - LW: MemRead = 1 until mem_ready, then WB.
  - SW: MemWrite = 1 until mem_ready; in that cycle instr_done = 1, next state FETCH.
- WB (1 cycle): RegWrite = 1, MemtoReg = 1 for LW else 0, instr_done = 1, next state FETCH.
- TRAP: all strobes 0; stays in TRAP until reset.
- Timeout counter:
  - Width $clog2(MEM_TIMEOUT+1). Clears on entry to FETCH/MEM and on mem_ready.
  - Increments on each waiting cycle in FETCH/MEM.
  - When it reaches MEM_TIMEOUT without mem_ready: next state TRAP, timeout = 1.
  - mem_ready in the same cycle the count hits the limit: ready wins, no trap.
  - mem_ready in non-memory states is ignored.
- Latency with zero-wait memory (mem_ready high in the first request cycle): BEQ 3 cycles, R/I/SW 4, LW 5.
- Reset mid-instruction: immediate return to FETCH; no strobe is held across reset.

Decomposition:
- Package ctrl_pkg holds:
  - state enum: FETCH, DECODE, EXEC, MEM, WB, TRAP.
  - instruction class enum: LOAD, STORE, RTYPE, ITYPE, BRANCH.
  - Opcode constants, ALUOp codes and ALUCtrl codes.
- Sub-module alu_ctrl_decode (combinational): class, funct3, funct7 -> ALUCtrl, illegal_op. Instantiated once, sampled in DECODE.
- The FSM, counter and output logic stay in multicycle_ctrl.

Test Plan:
- Reset low mid-FETCH with MemRead high -> next sample: state FETCH, MemRead 0, illegal 0, timeout 0; after release, MemRead 1.
- LW (0000011/010), mem_ready always 1 -> states FETCH, DECODE, EXEC, MEM, WB. MemRead in FETCH and MEM, RegWrite=1 and MemtoReg=1 in WB, instr_done after 5 cycles.
- SUB (0110011/000/0100000), then AND (111/0000000), then ADDI (0010011/000, funct7 0100000) -> ALUCtrl 0110, then 0000, then 0010. ALUSrc 0, 0, 1. 4 cycles each.
- SW with mem_ready delayed 3 cycles in MEM -> MemWrite high for exactly 4 cycles, instr_done in the ready cycle, RegWrite never 1.
- BEQ (1100011/000) -> Branch=1, ALUOp=01, ALUCtrl=0110 in EXEC; 3-cycle retire.
- Opcode 1111111 -> TRAP, illegal=1, all strobes 0 for 20 cycles. Separately, MEM_TIMEOUT=4 with mem_ready held 0 in FETCH -> TRAP and timeout=1 after 4 wait cycles. mem_ready on the 4th cycle -> no trap.
